alarm_time_ctrl: RTL and testbench



---
 rtl/alarm_pkg.sv | 23 ++
 rtl/alarm_tick_gen.sv | 30 +++
 rtl/alarm_time_ctrl.sv | 80 ++++++++
 tb/tb_alarm_time_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// alarm_pkg: field encodings, widths and wrap helpers shared by the alarm core and VGA renderer.
package alarm_pkg;
  localparam int HOUR_W = 5;
  localparam int MIN_W = 6;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
  typedef enum logic [2:0] {RUN = 3'd0, SET_H = 3'd1, SET_M = 3'd2, SET_S = 3'd3, ALM_H = 3'd4, ALM_M = 3'd5} state_t;
  localparam logic [2:0] FIELD_NONE = 3'd0;
  localparam logic [2:0] FIELD_HOUR = 3'd1;
  localparam logic [2:0] FIELD_MIN = 3'd2;
  localparam logic [2:0] FIELD_SEC = 3'd3;
  localparam logic [2:0] FIELD_ALM_HOUR = 3'd4;
  localparam logic [2:0] FIELD_ALM_MIN = 3'd5;
  function automatic state_t next_field(state_t s);
    return s == ALM_M ? RUN : state_t'(s + 3'd1);
  endfunction
  function automatic logic [HOUR_W-1:0] inc_hour(logic [HOUR_W-1:0] h);
    return h == HOUR_MAX ? '0 : h + 5'd1;
  endfunction
  function automatic logic [MIN_W-1:0] inc_min(logic [MIN_W-1:0] m);
    return m == MIN_MAX ? '0 : m + 6'd1;
  endfunction
endpackage

// File: rtl/alarm_tick_gen.sv
// alarm_tick_gen: one-second tick (held while not running) and free-running 2 Hz blink.
module alarm_tick_gen #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sec_tick,
  output logic blink
);
  localparam int PW = $clog2(CLK_FREQ + 1);
  localparam int BDIV = CLK_FREQ / 4;
  localparam int BW = $clog2(BDIV + 1);
  logic [PW-1:0] pre;
  logic [BW-1:0] bcnt;
  logic bwrap;
  assign sec_tick = run && pre == PW'(CLK_FREQ - 1);
  assign bwrap = bcnt == BW'(BDIV - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      bcnt <= '0;
      blink <= 1'b0;
    end else begin
      pre <= (!run || sec_tick) ? '0 : pre + PW'(1);
      bcnt <= bwrap ? '0 : bcnt + BW'(1);
      blink <= blink ^ bwrap;
    end
  end
endmodule

// File: rtl/alarm_time_ctrl.sv
// alarm_time_ctrl: clock/alarm registers, key-driven setting FSM and ring control.
module alarm_time_ctrl
  import alarm_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int ALM_H_INIT = 7,
  parameter int ALM_M_INIT = 0,
  parameter int RING_SEC = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_ctrl_pulse,
  input  logic key_add_pulse,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [4:0] alm_hour,
  output logic [5:0] alm_min,
  output logic [2:0] edit_field,
  output logic blink,
  output logic alarm_on
);
  state_t state, state_nx;
  logic sec_tick, dismiss, add, trigger, alarm_on_nx;
  logic [4:0] hour_nx, alm_hour_nx;
  logic [5:0] min_nx, sec_nx, alm_min_nx, ring_cnt, ring_nx;
  alarm_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
    .clk(clk),
    .rst_n(rst_n),
    .run(state == RUN),
    .sec_tick(sec_tick),
    .blink(blink)
  );
  assign edit_field = state;
  always_comb begin
    dismiss = alarm_on && (key_ctrl_pulse || key_add_pulse);
    add = key_add_pulse && !key_ctrl_pulse && !alarm_on;
    state_nx = (key_ctrl_pulse && !alarm_on) ? next_field(state) : state;
    sec_nx = sec_tick ? inc_min(sec) : (add && state == SET_S) ? inc_min(sec) : sec;
    min_nx = (sec_tick && sec == MIN_MAX) || (add && state == SET_M) ? inc_min(min) : min;
    hour_nx = (sec_tick && sec == MIN_MAX && min == MIN_MAX) || (add && state == SET_H) ? inc_hour(hour) : hour;
    alm_hour_nx = (add && state == ALM_H) ? inc_hour(alm_hour) : alm_hour;
    alm_min_nx = (add && state == ALM_M) ? inc_min(alm_min) : alm_min;
    // sec_tick only fires in RUN, so edits never reach the compare
    trigger = sec_tick && hour_nx == alm_hour && min_nx == alm_min && sec_nx == '0;
    alarm_on_nx = alarm_on;
    ring_nx = ring_cnt;
    if (dismiss) begin
      alarm_on_nx = 1'b0;
      ring_nx = '0;
    end else if (trigger) begin
      alarm_on_nx = 1'b1;
      ring_nx = 6'(RING_SEC);
    end else if (alarm_on && sec_tick) begin
      alarm_on_nx = ring_cnt != 6'd1;
      ring_nx = ring_cnt - 6'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      hour <= '0;
      min <= '0;
      sec <= '0;
      alm_hour <= 5'(ALM_H_INIT);
      alm_min <= 6'(ALM_M_INIT);
      alarm_on <= 1'b0;
      ring_cnt <= '0;
    end else begin
      state <= state_nx;
      hour <= hour_nx;
      min <= min_nx;
      sec <= sec_nx;
      alm_hour <= alm_hour_nx;
      alm_min <= alm_min_nx;
      alarm_on <= alarm_on_nx;
      ring_cnt <= ring_nx;
    end
  end
endmodule

// File: tb/tb_alarm_time_ctrl.sv
// tb_alarm_time_ctrl: key-vector tables with a scoreboard queue plus hand-timed tick/alarm sequences.
module tb_alarm_time_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic key_ctrl_pulse = 1'b0;
  logic key_add_pulse = 1'b0;
  logic [4:0] hour, alm_hour;
  logic [5:0] min, sec, alm_min;
  logic [2:0] edit_field;
  logic blink, alarm_on;
  int n_cmp = 0;
  int n_err = 0;
  typedef struct {
    int rst, c, a, ef, h, m, s, ah, am;
  } vec_t;
  vec_t vecs[$];
  vec_t sb[$];
  int eef, eh, em, es, eah, eam;
  alarm_time_ctrl #(.CLK_FREQ(8), .ALM_H_INIT(7), .ALM_M_INIT(0), .RING_SEC(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_ctrl_pulse(key_ctrl_pulse),
    .key_add_pulse(key_add_pulse),
    .hour(hour),
    .min(min),
    .sec(sec),
    .alm_hour(alm_hour),
    .alm_min(alm_min),
    .edit_field(edit_field),
    .blink(blink),
    .alarm_on(alarm_on)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic push_rst();
    eef = 0; eh = 0; em = 0; es = 0; eah = 7; eam = 0;
    vecs.push_back('{1, 0, 0, eef, eh, em, es, eah, eam});
  endtask
  task automatic push_key(input int c, input int a, input int n);
    for (int i = 0; i < n; i++) begin
      if (c != 0) eef = (eef == 5) ? 0 : eef + 1;
      else if (a != 0) begin
        if (eef == 1) eh = (eh + 1) % 24;
        if (eef == 2) em = (em + 1) % 60;
        if (eef == 3) es = (es + 1) % 60;
        if (eef == 4) eah = (eah + 1) % 24;
        if (eef == 5) eam = (eam + 1) % 60;
      end
      vecs.push_back('{0, c, a, eef, eh, em, es, eah, eam});
    end
  endtask
  task automatic apply(input int lo, input int hi);
    vec_t e;
    for (int i = lo; i < hi; i++) begin
      if (vecs[i].rst != 0) begin
        @(negedge clk);
        rst_n = 1'b0;
        sb.push_back(vecs[i]);
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        key_ctrl_pulse = vecs[i].c[0];
        key_add_pulse = vecs[i].a[0];
        sb.push_back(vecs[i]);
        @(negedge clk);
        key_ctrl_pulse = 1'b0;
        key_add_pulse = 1'b0;
      end
      e = sb.pop_front();
      chk($sformatf("vec%0d edit_field", i), edit_field, e.ef);
      chk($sformatf("vec%0d hour", i), hour, e.h);
      chk($sformatf("vec%0d min", i), min, e.m);
      chk($sformatf("vec%0d sec", i), sec, e.s);
      chk($sformatf("vec%0d alm_hour", i), alm_hour, e.ah);
      chk($sformatf("vec%0d alm_min", i), alm_min, e.am);
    end
  endtask
  task automatic ring(input bit dismiss);
    repeat (479) @(negedge clk);
    chk("pre_alarm alarm_on", alarm_on, 0);
    chk("pre_alarm sec", sec, 59);
    chk("pre_alarm min", min, 0);
    @(negedge clk);
    chk("alarm rise alarm_on", alarm_on, 1);
    chk("alarm rise hour", hour, 0);
    chk("alarm rise min", min, 1);
    chk("alarm rise sec", sec, 0);
    if (!dismiss) begin
      repeat (16) @(negedge clk);
      chk("ring after 2 ticks alarm_on", alarm_on, 1);
      repeat (8) @(negedge clk);
      chk("ring after 3 ticks alarm_on", alarm_on, 0);
    end else begin
      repeat (4) @(negedge clk);
      chk("ring before dismiss alarm_on", alarm_on, 1);
      key_add_pulse = 1'b1;
      @(negedge clk);
      key_add_pulse = 1'b0;
      chk("dismiss alarm_on", alarm_on, 0);
      chk("dismiss min", min, 1);
      chk("dismiss edit_field", edit_field, 0);
      chk("dismiss alm_min", alm_min, 1);
      repeat (19) @(negedge clk);
      chk("after dismiss alarm_on", alarm_on, 0);
    end
  endtask
  initial begin
    int a0, a1, b1, c1, d1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset hour", hour, 0);
    chk("reset min", min, 0);
    chk("reset sec", sec, 0);
    chk("reset alm_hour", alm_hour, 7);
    chk("reset alm_min", alm_min, 0);
    chk("reset edit_field", edit_field, 0);
    chk("reset blink", blink, 0);
    chk("reset alarm_on", alarm_on, 0);
    a0 = vecs.size();
    push_rst(); push_key(1, 0, 1); push_key(0, 1, 25);
    push_key(1, 0, 1); push_key(0, 1, 1);
    vecs.push_back('{0, 1, 1, 3, eh, em, es, eah, eam});
    eef = 3;
    push_key(1, 0, 3);
    a1 = vecs.size();
    push_rst(); push_key(1, 0, 1); push_key(0, 1, 23); push_key(1, 0, 1); push_key(0, 1, 59);
    push_key(1, 0, 1); push_key(0, 1, 58); push_key(1, 0, 3);
    b1 = vecs.size();
    push_rst(); push_key(1, 0, 4); push_key(0, 1, 17); push_key(1, 0, 1); push_key(0, 1, 1); push_key(1, 0, 1);
    c1 = vecs.size();
    push_rst(); push_key(1, 0, 1); push_key(0, 1, 12); push_key(1, 0, 1); push_key(0, 1, 34);
    push_key(1, 0, 1); push_key(0, 1, 56);
    d1 = vecs.size();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 480; k++) begin
      @(negedge clk);
      if (k % 8 == 0) chk($sformatf("run sec k=%0d", k), sec, (k / 8) % 60);
      if (k <= 16) chk($sformatf("blink k=%0d", k), blink, (k / 2) % 2);
    end
    chk("run 60s min", min, 1);
    chk("run 60s edit_field", edit_field, 0);
    apply(a0, a1);
    apply(a1, b1);
    repeat (8) @(negedge clk);
    chk("roll tick1 hour", hour, 23);
    chk("roll tick1 min", min, 59);
    chk("roll tick1 sec", sec, 59);
    repeat (7) @(negedge clk);
    chk("roll pre tick2 sec", sec, 59);
    @(negedge clk);
    chk("roll tick2 hour", hour, 0);
    chk("roll tick2 min", min, 0);
    chk("roll tick2 sec", sec, 0);
    apply(b1, c1);
    ring(1'b0);
    apply(b1, c1);
    ring(1'b1);
    apply(c1, d1);
    #3 rst_n = 1'b0;
    #1;
    chk("async rst hour", hour, 0);
    chk("async rst min", min, 0);
    chk("async rst sec", sec, 0);
    chk("async rst alm_hour", alm_hour, 7);
    chk("async rst alm_min", alm_min, 0);
    chk("async rst edit_field", edit_field, 0);
    chk("async rst alarm_on", alarm_on, 0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
